sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised synchronous FIFO for single-clock data buffering between producer and consumer stages; successor to the team's fixed 8-entry FIFO. It adds:
- any depth of 2 or more, with explicit pointer wrap;
- a live occupancy count and programmable almost-full / almost-empty thresholds;
- write acceptance while full when a read is accepted in the same cycle;
- optional sticky overflow/underflow error flags.

## Interface
Clock: single clock `clk`. Reset: `rst_n`, synchronous, active-low.

Parameters:
- DEPTH, 8, number of entries; legal range ≥ 2, power of two not required
- DATA_WIDTH, 8, entry width in bits
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH; legal 1..DEPTH
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH; legal 0..DEPTH-1

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- wren  in  1  write request
- i_data  in  DATA_WIDTH  write data
- rden  in  1  read request
- o_data  out  DATA_WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  CW  current occupancy
- err_clr  in  1  clears sticky error flags
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation
- Acceptance:
  - rd_acc = rden && !empty
  - wr_acc = wren && (!full || rd_acc)
- No empty bypass: a read on empty is rejected even when a write is accepted in the same cycle.
- Accepted write: mem[wr_ptr] ← i_data; wr_ptr advances and wraps from DEPTH-1 to 0.
- Accepted read: o_data ← mem[rd_ptr]; rd_ptr advances with the same wrap rule.
- o_data holds its last value on cycles with no accepted read.
- Count update:
  - +1 on write-only
  - −1 on read-only
  - unchanged when both or neither are accepted
- Pointers are ⌈log2 DEPTH⌉ bits with compare-and-reset wrap; no reliance on natural overflow.
- Status outputs are combinational from the count register.
- Reset (rst_n low at a rising edge):
  - wr_ptr, rd_ptr, count, o_data, overflow, underflow all go to 0
  - empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 → never; otherwise 0)
  - memory contents are not reset
- Reset asserted mid-operation discards all contents at that edge; requests in that cycle are ignored.

## Timing
- Write latency: data written at edge N can be read by a read accepted at edge N+1, and appears on o_data after that edge.
- Read latency: o_data is valid one cycle after the rden cycle, updated at the accepting edge.
- count, flags and thresholds reflect the new occupancy immediately after the updating edge.
- Full with wren && rden: both accepted; count stays DEPTH; full stays 1.
- Empty with wren && rden: write only; count goes to 1; o_data unchanged.

## Configuration
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any cycle with wren && !wr_acc
  - underflow sets on any cycle with rden && !rd_acc
  - both hold until an err_clr cycle; set has priority over clear in the same cycle
- Undefined:
  - overflow and underflow are tied to 0
  - err_clr is ignored
  - no flag registers are built
- Ports are present in both builds.

## Structure
- Package sync_fifo_pkg holds:
  - default parameter constants
  - function cnt_width(depth) returning $clog2(depth+1)
  - struct sync_fifo_status_t {full, empty, almost_full, almost_empty}, used by parent blocks to bundle status
- Sub-module sync_fifo_mem holds the storage array with a write port and a registered read port with enable.
- The top level holds pointers, count, acceptance logic and error flags.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=1 unless stated.
- Fill then drain: write 0x10..0x17, then read 8 times → o_data 0x10..0x17 in order; full=1 at count 8; empty=1 at the end; almost_full asserts when count reaches 6.
- Full with simultaneous read/write: fill with 0xA0..0xA7, then one cycle of wren=1 (0xB0) and rden=1 → o_data=0xA0, count=8; 7 more reads give 0xA1..0xA7, and the 8th read gives 0xB0.
- Empty with simultaneous read/write: empty FIFO, wren=1 (0x55) and rden=1 → count=1, o_data unchanged; next read → 0x55.
- Non-power-of-two wrap, DEPTH=5: 20 interleaved write/read pairs with data 0..19 → read order 0..19 and no corruption across the 4→0 pointer wrap.
- Error flags, SYNC_FIFO_ERR_FLAGS_EN defined:
  - wren on full without rden → overflow=1, count unchanged
  - rden on empty → underflow=1, o_data unchanged
  - err_clr → both 0
  - err_clr together with a new overflow → overflow stays 1
  - rebuild with the macro undefined → flags stay 0
- Mid-operation reset: load 3 entries, drive rst_n=0 for one edge with wren=1 → count=0, empty=1, o_data=0, flags=0; a subsequent write/read of 0x3C returns 0x3C.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared definitions for the sync_fifo family.
//   - default parameter constants
//   - cnt_width(depth): width of an occupancy counter able to hold 0..depth
//   - sync_fifo_status_t: status bundle for parent blocks
package sync_fifo_pkg;

  localparam int DEF_DEPTH      = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_AE_THRESH  = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } sync_fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: storage array for sync_fifo.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata loads mem[raddr] when set
//   raddr  in   read address
//   rdata  out  registered read data, holds when re is low
// The array itself is never reset.
module sync_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and write-while-full when a read
// is accepted in the same cycle. No empty bypass.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN builds sticky
// overflow/underflow flags; without it both outputs are tied low.
// Ports:
//   clk, rst_n                 clock / synchronous active-low reset
//   wren, i_data               write request and data
//   rden, o_data               read request, registered read data
//   full, empty                count == DEPTH / count == 0
//   almost_full, almost_empty  count >= AF_THRESH / count <= AE_THRESH
//   count                      current occupancy
//   err_clr                    clears sticky error flags
//   overflow, underflow        sticky rejected-write / rejected-read flags
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wren,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         rden,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              wr_acc, rd_acc;
  sync_fifo_status_t status;

  // Compare-and-reset wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    status              = '0;
    status.full         = (count == DEPTH_C);
    status.empty        = (count == '0);
    status.almost_full  = (AF_THRESH != 0) && (count >= AF_C);
    status.almost_empty = (count <= AE_C);
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // when the read is accepted; the converse (read on empty) is never bypassed.
  assign rd_acc = rden && !status.empty;
  assign wr_acc = wren && (!status.full || rd_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  sync_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc && rst_n),
    .waddr (wr_ptr),
    .wdata (i_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (o_data)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Set wins over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wren && !wr_acc)  overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;
      if (rden && !rd_acc)  underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo (DEPTH=8 instance with
// AF_THRESH=6/AE_THRESH=1, plus a DEPTH=5 instance for wrap checks).
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wren, rden, err_clr;
  logic [7:0] i_data, o_data;
  logic       full, empty, af, ae, ovf, udf;
  logic [3:0] count;

  logic       w5, r5, ec5;
  logic [7:0] d5, o5;
  logic       full5, empty5, af5, ae5, ovf5, udf5;
  logic [2:0] count5;

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .AF_THRESH(6), .AE_THRESH(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(o_data), .full(full), .empty(empty), .almost_full(af),
    .almost_empty(ae), .count(count), .err_clr(err_clr),
    .overflow(ovf), .underflow(udf)
  );

  sync_fifo #(.DEPTH(5), .DATA_WIDTH(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .wren(w5), .i_data(d5), .rden(r5),
    .o_data(o5), .full(full5), .empty(empty5), .almost_full(af5),
    .almost_empty(ae5), .count(count5), .err_clr(ec5),
    .overflow(ovf5), .underflow(udf5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queue of stored entries plus last read value.
  logic [7:0] q[$];
  logic [7:0] m_o;
  logic       m_ovf, m_udf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc8(input logic w, input logic r, input logic [7:0] d, input logic c);
    bit ra, wa;
    wren = w; rden = r; i_data = d; err_clr = c;
    ra = r && (q.size() != 0);
    wa = w && ((q.size() < 8) || ra);
    @(posedge clk); #1;
    if (ra) m_o = q.pop_front();
    if (wa) q.push_back(d);
    if (ERR_EN) begin
      if (w && !wa) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && !ra) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    end
    wren = 1'b0; rden = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check8(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"},  32'(full),  32'(n == 8));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".af"},    32'(af),    32'(n >= 6));
    chk({tag, ".ae"},    32'(ae),    32'(n <= 1));
    chk({tag, ".odata"}, 32'(o_data), 32'(m_o));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".udf"},   32'(udf),   32'(m_udf));
  endtask

  task automatic do_reset(input logic w_during);
    rst_n = 1'b0; wren = w_during; i_data = 8'hEE;
    @(posedge clk); #1;
    rst_n = 1'b1; wren = 1'b0;
    q.delete(); m_o = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  typedef struct {
    logic       w, r;
    logic [7:0] d;
    int         cnt;
    logic       full, empty, af, ae;
    logic [7:0] o;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0; wren = 0; rden = 0; err_clr = 0; i_data = 0;
    w5 = 0; r5 = 0; ec5 = 0; d5 = 0;
    q.delete(); m_o = 0; m_ovf = 0; m_udf = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full",  32'(full),  0);
    chk("rst.ae",    32'(ae),    1);
    chk("rst.af",    32'(af),    0);
    chk("rst.odata", 32'(o_data), 0);
    chk("rst.ovf",   32'(ovf),   0);
    chk("rst.udf",   32'(udf),   0);

    // Fill then drain, table-driven
    for (int i = 0; i < 8; i++) begin
      tbl[i].w = 1; tbl[i].r = 0; tbl[i].d = 8'h10 + 8'(i);
      tbl[i].cnt = i + 1; tbl[i].full = (i == 7); tbl[i].empty = 0;
      tbl[i].af = (i + 1 >= 6); tbl[i].ae = (i + 1 <= 1); tbl[i].o = 8'h00;
    end
    for (int i = 0; i < 8; i++) begin
      tbl[8+i].w = 0; tbl[8+i].r = 1; tbl[8+i].d = 8'h00;
      tbl[8+i].cnt = 7 - i; tbl[8+i].full = 0; tbl[8+i].empty = (i == 7);
      tbl[8+i].af = (7 - i >= 6); tbl[8+i].ae = (7 - i <= 1); tbl[8+i].o = 8'h10 + 8'(i);
    end
    for (int i = 0; i < 16; i++) begin
      cyc8(tbl[i].w, tbl[i].r, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.full", i),  32'(full),  32'(tbl[i].full));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].empty));
      chk($sformatf("tbl%0d.af", i),    32'(af),    32'(tbl[i].af));
      chk($sformatf("tbl%0d.ae", i),    32'(ae),    32'(tbl[i].ae));
      chk($sformatf("tbl%0d.odata", i), 32'(o_data), 32'(tbl[i].o));
    end

    // Full with simultaneous read/write
    for (int i = 0; i < 8; i++) cyc8(1, 0, 8'hA0 + 8'(i), 0);
    cyc8(1, 1, 8'hB0, 0);
    chk("fullrw.odata", 32'(o_data), 32'h A0);
    chk("fullrw.count", 32'(count), 8);
    chk("fullrw.full",  32'(full), 1);
    for (int i = 1; i < 8; i++) begin
      cyc8(0, 1, 0, 0);
      chk($sformatf("fullrw.rd%0d", i), 32'(o_data), 32'(8'hA0 + 8'(i)));
    end
    cyc8(0, 1, 0, 0);
    chk("fullrw.last", 32'(o_data), 32'h B0);
    check8("fullrw");

    // Empty with simultaneous read/write: write only
    cyc8(1, 1, 8'h55, 0);
    chk("emptyrw.count", 32'(count), 1);
    chk("emptyrw.odata", 32'(o_data), 32'h B0);
    chk("emptyrw.udf",   32'(udf), 32'(ERR_EN));
    cyc8(0, 1, 0, 0);
    chk("emptyrw.rd", 32'(o_data), 32'h 55);
    cyc8(0, 0, 0, 1);
    check8("emptyrw");

    // Error flags
    for (int i = 0; i < 8; i++) cyc8(1, 0, 8'hC0 + 8'(i), 0);
    cyc8(1, 0, 8'h99, 0);
    chk("err.ovf",       32'(ovf), 32'(ERR_EN));
    chk("err.ovf_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) cyc8(0, 1, 0, 0);
    cyc8(0, 1, 0, 0);
    chk("err.udf",       32'(udf), 32'(ERR_EN));
    chk("err.udf_odata", 32'(o_data), 32'h C7);
    chk("err.udf_ovf",   32'(ovf), 32'(ERR_EN));
    cyc8(0, 0, 0, 1);
    chk("err.clr_ovf", 32'(ovf), 0);
    chk("err.clr_udf", 32'(udf), 0);
    for (int i = 0; i < 8; i++) cyc8(1, 0, 8'(i), 0);
    cyc8(1, 0, 8'h77, 1);
    chk("err.setclr_ovf", 32'(ovf), 32'(ERR_EN));
    check8("err");
    cyc8(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc8(0, 1, 0, 0);
    check8("err.drain");

    // Mid-operation reset
    cyc8(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc8(1, 0, 8'h20 + 8'(i), 0);
    cyc8(0, 1, 0, 0);
    do_reset(1'b1);
    chk("midrst.count", 32'(count), 0);
    chk("midrst.empty", 32'(empty), 1);
    chk("midrst.odata", 32'(o_data), 0);
    chk("midrst.ovf",   32'(ovf), 0);
    chk("midrst.udf",   32'(udf), 0);
    cyc8(1, 0, 8'h3C, 0);
    cyc8(0, 1, 0, 0);
    chk("midrst.rd", 32'(o_data), 32'h 3C);
    check8("midrst");

    // Randomised traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      int wp;
      logic w, r, c;
      wp = (i < 200) ? 70 : 30;
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < 100 - wp + 10);
      c = ($urandom_range(0, 19) == 0);
      cyc8(w, r, 8'($urandom), c);
      check8($sformatf("rnd%0d", i));
    end

    // DEPTH=5 wrap: write i then read it back, 20 times across pointer wrap
    for (int i = 0; i < 20; i++) begin
      w5 = 1; d5 = 8'(i);
      @(posedge clk); #1;
      w5 = 0;
      chk($sformatf("d5.cnt%0d", i), 32'(count5), 1);
      r5 = 1;
      @(posedge clk); #1;
      r5 = 0;
      chk($sformatf("d5.rd%0d", i), 32'(o5), 32'(i));
      chk($sformatf("d5.empty%0d", i), 32'(empty5), 1);
    end
    // DEPTH=5 fill to full across the wrapped pointers, then drain
    for (int i = 0; i < 5; i++) begin
      w5 = 1; d5 = 8'h80 + 8'(i);
      @(posedge clk); #1;
    end
    w5 = 0;
    chk("d5.full", 32'(full5), 1);
    chk("d5.count", 32'(count5), 5);
    for (int i = 0; i < 5; i++) begin
      r5 = 1;
      @(posedge clk); #1;
      chk($sformatf("d5.drain%0d", i), 32'(o5), 32'(8'h80 + 8'(i)));
    end
    r5 = 0;
    chk("d5.end_empty", 32'(empty5), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
